// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and active geometry from sampled VGA hsync/vsync/de, and declares lock on stable geometry.
// Latency: one enabled sample. No backpressure: strictly follows pix_en_i. Pulses clear on the next clk_i.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int XW          = 10,
    parameter int YW          = 10,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          pix_en_i,
    input  logic          hsync_i,
    input  logic          vsync_i,
    input  logic          de_i,
    output logic          de_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic [XW-1:0] h_meas_o,
    output logic [YW-1:0] v_meas_o,
    output logic          locked_o,
    output logic          err_o
);

    localparam logic [XW-1:0] H_EXP  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_MAX  = {XW{1'b1}};
    localparam logic [YW-1:0] V_EXP  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_MAX  = {YW{1'b1}};
    localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Sync samples are stored as "active" flags so SYNC_POL only appears here.
    logic hs_act, vs_act;
    assign hs_act = (hsync_i == SYNC_POL);
    assign vs_act = (vsync_i == SYNC_POL);

    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic [XW-1:0] x_q, x_d;
    logic [XW-1:0] cnt_q, cnt_d;
    logic [YW-1:0] y_q, y_d;
    logic          lbad_q, lbad_d;
    logic          fbad_q, fbad_d;
    logic [XW-1:0] h_meas_q, h_meas_d;
    logic [YW-1:0] v_meas_q, v_meas_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    state_t        state_q;
    logic [3:0]    gcnt_q;
    logic          locked_q;
    logic          err_q;

    logic          de_rise, de_hold, de_fall, vs_rise;
    logic          x_sat, line_bad;
    logic [YW-1:0] y_line;
    logic          fbad_line, frame_good;

    assign de_rise = pix_en_i && de_i && !de_q;
    assign de_hold = pix_en_i && de_i && de_q;
    assign de_fall = pix_en_i && !de_i && de_q;
    assign vs_rise = pix_en_i && vs_act && !vs_q;

    assign x_sat    = (x_q == X_MAX);
    assign line_bad = lbad_q || (cnt_q != H_EXP);

    // Line end is folded in before the frame end, so a de fall coinciding
    // with vsync assertion still counts toward the frame being closed.
    assign y_line     = de_fall ? ((y_q == Y_MAX) ? y_q : y_q + 1'b1) : y_q;
    assign fbad_line  = fbad_q || (de_fall && line_bad);
    assign frame_good = (y_line == V_EXP) && !fbad_line;

    always_comb begin
        vs_d     = vs_q;
        de_d     = de_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        lbad_d   = lbad_q;
        fbad_d   = fbad_q;
        h_meas_d = h_meas_q;
        v_meas_d = v_meas_q;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        if (pix_en_i) begin
            vs_d = vs_act;
            de_d = de_i;
            if (de_rise) begin
                x_d    = '0;
                cnt_d  = XW'(1);
                lbad_d = hs_act;
                ls_d   = 1'b1;
            end else if (de_hold) begin
                x_d    = x_sat ? x_q : x_q + 1'b1;
                cnt_d  = (cnt_q == X_MAX) ? cnt_q : cnt_q + 1'b1;
                lbad_d = lbad_q || hs_act || x_sat;
            end
            if (de_fall) begin
                h_meas_d = cnt_q;
                lbad_d   = 1'b0;
            end
            y_d    = y_line;
            fbad_d = fbad_line;
            if (vs_rise) begin
                v_meas_d = y_line;
                y_d      = '0;
                fbad_d   = 1'b0;
                fs_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vs_q     <= 1'b0;
            de_q     <= 1'b0;
            x_q      <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            lbad_q   <= 1'b0;
            fbad_q   <= 1'b0;
            h_meas_q <= '0;
            v_meas_q <= '0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            vs_q     <= vs_d;
            de_q     <= de_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            lbad_q   <= lbad_d;
            fbad_q   <= fbad_d;
            h_meas_q <= h_meas_d;
            v_meas_q <= v_meas_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    // Leaving LOCKED drops to ACQUIRE, so a frame can raise at most one err_o.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= SEARCH;
            gcnt_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (pix_en_i) begin
                case (state_q)
                    SEARCH: begin
                        if (vs_rise) begin
                            state_q <= ACQUIRE;
                            gcnt_q  <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (vs_rise) begin
                            if (frame_good) begin
                                gcnt_q <= gcnt_q + 1'b1;
                                if (gcnt_q + 4'd1 == LOCK_N) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                gcnt_q <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if ((de_fall && line_bad) || (vs_rise && !frame_good)) begin
                            state_q  <= ACQUIRE;
                            gcnt_q   <= '0;
                            locked_q <= 1'b0;
                            err_q    <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= SEARCH;
                        gcnt_q   <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign de_o          = de_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign line_start_o  = ls_q;
    assign frame_start_o = fs_q;
    assign h_meas_o      = h_meas_q;
    assign v_meas_o      = v_meas_q;
    assign locked_o      = locked_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: an active-low and an active-high instance receive the same timing with
// opposite sync polarity; per-sample expectations go through a scoreboard queue, frame outcomes come from a table.
module tb_vga_sync_decoder;

    localparam int XW = 10;
    localparam int YW = 10;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;
    logic de_in;
    logic hs_act;
    logic vs_act;

    always #5 clk = ~clk;

    typedef struct packed {
        logic          de;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          ls;
        logic          fs;
        logic [XW-1:0] h;
        logic [YW-1:0] v;
        logic          locked;
        logic          err;
    } obs_t;

    typedef struct {
        logic de;
        int   x;
        int   y;
        logic ls;
        logic fs;
        logic chk_h;
        int   h;
    } exp_t;

    typedef struct {
        int nlines;
        int short_idx;
        int short_len;
        int lock_vs;
        int v_vs;
        int errs;
        int lock_end;
    } fvec_t;

    obs_t obs[2];

    logic          de_o0, ls0, fs0, lk0, er0;
    logic [XW-1:0] x0, h0;
    logic [YW-1:0] y0, v0;
    logic          de_o1, ls1, fs1, lk1, er1;
    logic [XW-1:0] x1, h1;
    logic [YW-1:0] y1, v1;

    vga_sync_decoder #(
        .H_ACTIVE(8), .V_ACTIVE(4), .XW(XW), .YW(YW), .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut_lo (
        .clk_i(clk), .reset_i(rst), .pix_en_i(pix_en),
        .hsync_i(~hs_act), .vsync_i(~vs_act), .de_i(de_in),
        .de_o(de_o0), .x_o(x0), .y_o(y0), .line_start_o(ls0), .frame_start_o(fs0),
        .h_meas_o(h0), .v_meas_o(v0), .locked_o(lk0), .err_o(er0)
    );

    vga_sync_decoder #(
        .H_ACTIVE(8), .V_ACTIVE(4), .XW(XW), .YW(YW), .SYNC_POL(1'b1), .LOCK_FRAMES(2)
    ) dut_hi (
        .clk_i(clk), .reset_i(rst), .pix_en_i(pix_en),
        .hsync_i(hs_act), .vsync_i(vs_act), .de_i(de_in),
        .de_o(de_o1), .x_o(x1), .y_o(y1), .line_start_o(ls1), .frame_start_o(fs1),
        .h_meas_o(h1), .v_meas_o(v1), .locked_o(lk1), .err_o(er1)
    );

    always_comb begin
        obs[0] = '{de_o0, x0, y0, ls0, fs0, h0, v0, lk0, er0};
        obs[1] = '{de_o1, x1, y1, ls1, fs1, h1, v1, lk1, er1};
    end

    int   checks = 0;
    int   failures = 0;
    int   err_cnt[2];
    exp_t sb[$];
    exp_t mon_e;
    fvec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic de, input int x, input int y, input logic ls,
                                input logic fs, input logic chk_h, input int h);
        exp_t e;
        e.de = de; e.x = x; e.y = y; e.ls = ls; e.fs = fs; e.chk_h = chk_h; e.h = h;
        return e;
    endfunction

    task automatic cmp(input int d, input obs_t o, input exp_t e);
        chk($sformatf("dut%0d_de", d), int'(o.de), int'(e.de));
        if (e.de) begin
            chk($sformatf("dut%0d_x", d), int'(o.x), e.x);
            chk($sformatf("dut%0d_y", d), int'(o.y), e.y);
        end
        chk($sformatf("dut%0d_line_start", d), int'(o.ls), int'(e.ls));
        chk($sformatf("dut%0d_frame_start", d), int'(o.fs), int'(e.fs));
        if (e.chk_h) chk($sformatf("dut%0d_h_meas", d), int'(o.h), e.h);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_dut%0d_de", tag, d), int'(obs[d].de), 0);
            chk($sformatf("%s_dut%0d_x", tag, d), int'(obs[d].x), 0);
            chk($sformatf("%s_dut%0d_y", tag, d), int'(obs[d].y), 0);
            chk($sformatf("%s_dut%0d_pulses", tag, d), int'({obs[d].ls, obs[d].fs, obs[d].err}), 0);
            chk($sformatf("%s_dut%0d_h_meas", tag, d), int'(obs[d].h), 0);
            chk($sformatf("%s_dut%0d_v_meas", tag, d), int'(obs[d].v), 0);
            chk($sformatf("%s_dut%0d_locked", tag, d), int'(obs[d].locked), 0);
        end
    endtask

    // Scoreboard side: every enabled edge consumes one expectation; other edges must show no pulses.
    always @(posedge clk) begin
        if (pix_en) begin
            #1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got sample with no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                for (int d = 0; d < 2; d++) begin
                    cmp(d, obs[d], mon_e);
                    if (obs[d].err) err_cnt[d]++;
                end
            end
        end else begin
            #1;
            for (int d = 0; d < 2; d++)
                chk($sformatf("dut%0d_pulse_clear", d), int'({obs[d].ls, obs[d].fs, obs[d].err}), 0);
        end
    end

    task automatic sample(input logic de, input logic hs, input logic vs, input exp_t e);
        @(negedge clk);
        de_in  = de;
        hs_act = hs;
        vs_act = vs;
        pix_en = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic drive_line(input int len, input int y, input int stall_at);
        for (int k = 0; k < len; k++) begin
            sample(1'b1, 1'b0, 1'b0, mk(1'b1, k, y, k == 0, 1'b0, 1'b0, 0));
            if (k == stall_at) begin
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    for (int d = 0; d < 2; d++)
                        chk($sformatf("dut%0d_stall_x", d), int'(obs[d].x), k);
                end
            end
        end
        sample(1'b0, 1'b0, 1'b0, mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, len));
        sample(1'b0, 1'b1, 1'b0, mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0));
        sample(1'b0, 1'b1, 1'b0, mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0));
        sample(1'b0, 1'b0, 1'b0, mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0));
    endtask

    task automatic drive_frame(input int idx, input fvec_t v);
        err_cnt[0] = 0;
        err_cnt[1] = 0;
        for (int i = 0; i < 4; i++)
            sample(1'b0, 1'b0, i < 2, mk(1'b0, 0, 0, 1'b0, i == 0, 1'b0, 0));
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("f%0d_dut%0d_locked_at_vsync", idx, d), int'(obs[d].locked), v.lock_vs);
            chk($sformatf("f%0d_dut%0d_v_meas", idx, d), int'(obs[d].v), v.v_vs);
        end
        for (int l = 0; l < v.nlines; l++)
            drive_line((l == v.short_idx) ? v.short_len : 8, l, -1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("f%0d_dut%0d_err_count", idx, d), err_cnt[d], v.errs);
            chk($sformatf("f%0d_dut%0d_locked_at_end", idx, d), int'(obs[d].locked), v.lock_end);
        end
    endtask

    initial begin
        // {lines, short line idx, short len, locked after vsync, v_meas after vsync, err pulses, locked at end}
        vt[0] = '{4, -1, 8, 0, 0, 0, 0};
        vt[1] = '{4, -1, 8, 0, 4, 0, 0};
        vt[2] = '{4, -1, 8, 1, 4, 0, 1};
        vt[3] = '{4,  1, 7, 1, 4, 1, 0};
        vt[4] = '{4, -1, 8, 0, 4, 0, 0};
        vt[5] = '{4, -1, 8, 0, 4, 0, 0};
        vt[6] = '{4, -1, 8, 1, 4, 0, 1};
        vt[7] = '{5, -1, 8, 1, 4, 0, 1};
        vt[8] = '{4, -1, 8, 0, 5, 1, 0};

        rst    = 1'b1;
        pix_en = 1'b0;
        de_in  = 1'b0;
        hs_act = 1'b0;
        vs_act = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            drive_frame(i, vt[i]);

        // Mid-line stall: x holds at 3, then continues; the full 8-pixel count survives.
        drive_line(8, 4, 3);

        // Asynchronous reset in the middle of a line.
        for (int k = 0; k < 4; k++)
            sample(1'b1, 1'b0, 1'b0, mk(1'b1, k, 5, k == 0, 1'b0, 1'b0, 0));
        for (int d = 0; d < 2; d++)
            chk($sformatf("dut%0d_x_before_reset", d), int'(obs[d].x), 3);
        #2;
        rst   = 1'b1;
        de_in = 1'b0;
        #1;
        chk_zero("midline_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++)
            drive_frame(10 + i, vt[i]);

        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
